// File: rtl/env_pkg.sv
// Shared definitions for the ADSR envelope stage: state encoding and level limits.
package env_pkg;

   localparam logic [2:0] ENV_IDLE    = 3'd0;
   localparam logic [2:0] ENV_ATTACK  = 3'd1;
   localparam logic [2:0] ENV_DECAY   = 3'd2;
   localparam logic [2:0] ENV_SUSTAIN = 3'd3;
   localparam logic [2:0] ENV_RELEASE = 3'd4;

   localparam logic [7:0] ENV_LEVEL_MAX = 8'd255;

   typedef enum logic [2:0] {
      ST_IDLE    = ENV_IDLE,
      ST_ATTACK  = ENV_ATTACK,
      ST_DECAY   = ENV_DECAY,
      ST_SUSTAIN = ENV_SUSTAIN,
      ST_RELEASE = ENV_RELEASE
   } env_state_e;

endpackage

// File: rtl/env_tick_gen.sv
// Envelope update prescaler: one-clock tick every TICK_DIV clocks.
module env_tick_gen #(
   parameter int TICK_DIV = 256
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   // Free-running counter, wraps after the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope: gate-driven level FSM and sample scaling.
// Build option: define ENV_EXP_RELEASE_EN for an exponential-like release
// (decrement max(1, level>>2) per tick, release_step ignored).
//
// state   | meaning
// IDLE    | silent, level held at 0
// ATTACK  | level ramps up by attack_step per tick until 255
// DECAY   | level ramps down by decay_step per tick until sustain_level
// SUSTAIN | level follows sustain_level until note off
// RELEASE | level ramps down to 0, then back to IDLE
module envelope_adsr
   import env_pkg::*;
#(
   parameter int TICK_DIV = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gate,
   input  logic [7:0] data_in,
   input  logic [7:0] attack_step,
   input  logic [7:0] decay_step,
   input  logic [7:0] sustain_level,
   input  logic [7:0] release_step,
   output logic [7:0] data_out,
   output logic       busy,
   output logic [7:0] level
);

   logic tick;

   env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   env_state_e state_q, state_d;
   logic [7:0] level_q, level_d;
   logic [7:0] data_out_q, data_out_d;
   logic       busy_q, busy_d;
   logic       gate_q;
   logic       armed_q;

   logic        rise, fall;
   logic [8:0]  attack_sum;
   logic signed [9:0] decay_diff;
   logic [7:0]  rel_dec;
   logic        rel_to_zero;
   logic [16:0] product;

   // A gate that is already high when reset releases has no preceding low
   // level, so it must not count as a note-on; armed_q records that the gate
   // has been seen low at least once since reset.
   assign rise = gate & ~gate_q & armed_q;
   assign fall = ~gate & gate_q &
                 ((state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN));

   assign attack_sum = {1'b0, level_q} + {1'b0, attack_step};
   assign decay_diff = $signed({2'b00, level_q}) - $signed({2'b00, decay_step});

`ifdef ENV_EXP_RELEASE_EN
   assign rel_dec     = (level_q[7:2] == 6'd0) ? 8'd1 : {2'b00, level_q[7:2]};
   assign rel_to_zero = 1'b0;
`else
   assign rel_dec     = release_step;
   assign rel_to_zero = (release_step == 8'd0);
`endif

   // Next state and level: gate edges take priority over tick updates.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (rise) begin
         state_d = ST_ATTACK;
      end else if (fall) begin
         state_d = ST_RELEASE;
      end else if (tick) begin
         case (state_q)
            ST_IDLE: begin
               level_d = 8'd0;
            end
            ST_ATTACK: begin
               if ((attack_step == 8'd0) || attack_sum[8]) begin
                  level_d = ENV_LEVEL_MAX;
               end else begin
                  level_d = attack_sum[7:0];
               end
               if (level_d == ENV_LEVEL_MAX) begin
                  state_d = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if ((decay_step == 8'd0) || (decay_diff <= $signed({2'b00, sustain_level}))) begin
                  level_d = sustain_level;
               end else begin
                  level_d = decay_diff[7:0];
               end
               if (level_d == sustain_level) begin
                  state_d = ST_SUSTAIN;
               end
            end
            ST_SUSTAIN: begin
               level_d = sustain_level;
            end
            ST_RELEASE: begin
               if (rel_to_zero || (rel_dec >= level_q)) begin
                  level_d = 8'd0;
               end else begin
                  level_d = level_q - rel_dec;
               end
               if (level_d == 8'd0) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               level_d = 8'd0;
            end
         endcase
      end
   end

   // Output scaling: (level+1)/256 gain so that level 255 is unity gain.
   always_comb begin
      product    = 17'(data_in) * 17'({1'b0, level_q} + 9'd1);
      busy_d     = (state_d != ST_IDLE);
      data_out_d = 8'd0;
      if (level_q != 8'd0) begin
         // Bit 16 cannot be set for 8-bit operands; saturate defensively anyway.
         data_out_d = product[16] ? 8'hFF : product[15:8];
      end
   end

   // State, level, output and gate history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         level_q    <= 8'd0;
         data_out_q <= 8'd0;
         busy_q     <= 1'b0;
         gate_q     <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         gate_q     <= gate;
         armed_q    <= armed_q | ~gate;
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign level    = level_q;

endmodule

// File: tb/tb_envelope_adsr.sv
// Self-checking bench for envelope_adsr with TICK_DIV=4: directed scenarios
// plus a randomized run against a behavioural envelope model.
module tb_envelope_adsr;

   localparam int TD = 4;

   localparam int S_IDLE = 0;
   localparam int S_ATT  = 1;
   localparam int S_DEC  = 2;
   localparam int S_SUS  = 3;
   localparam int S_REL  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gate = 1'b0;
   logic [7:0] data_in = 8'hFF;
   logic [7:0] attack_step = 8'd64;
   logic [7:0] decay_step = 8'd32;
   logic [7:0] sustain_level = 8'h80;
   logic [7:0] release_step = 8'h40;
   logic [7:0] data_out;
   logic       busy;
   logic [7:0] level;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state
   int m_st, m_lv, m_out, m_cnt;
   bit m_gq, m_armed;

   envelope_adsr #(.TICK_DIV(TD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gate          (gate),
      .data_in       (data_in),
      .attack_step   (attack_step),
      .decay_step    (decay_step),
      .sustain_level (sustain_level),
      .release_step  (release_step),
      .data_out      (data_out),
      .busy          (busy),
      .level         (level)
   );

   always #5 clk = ~clk;

   // Behavioural envelope: gate edges beat ticks, levels follow min/max rules.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= S_IDLE; m_lv <= 0; m_out <= 0; m_cnt <= 0; m_gq <= 0; m_armed <= 0;
      end else begin
         int st, lv, dec;
         bit tk, rise, fall;
         st = m_st;
         lv = m_lv;
         tk = (m_cnt == TD - 1);
         rise = gate && !m_gq && m_armed;
         fall = !gate && m_gq && (st == S_ATT || st == S_DEC || st == S_SUS);
         if (rise) st = S_ATT;
         else if (fall) st = S_REL;
         else if (tk) begin
            case (st)
               S_IDLE: lv = 0;
               S_ATT: begin
                  lv = (attack_step == 0) ? 255 : ((lv + attack_step > 255) ? 255 : lv + attack_step);
                  if (lv == 255) st = S_DEC;
               end
               S_DEC: begin
                  lv = (decay_step == 0) ? sustain_level :
                       ((lv - int'(decay_step) < int'(sustain_level)) ? sustain_level : lv - decay_step);
                  if (lv == sustain_level) st = S_SUS;
               end
               S_SUS: lv = sustain_level;
               default: begin
`ifdef ENV_EXP_RELEASE_EN
                  dec = (lv / 4 < 1) ? 1 : lv / 4;
                  lv = (lv - dec < 0) ? 0 : lv - dec;
`else
                  dec = release_step;
                  lv = (dec == 0 || lv - dec < 0) ? 0 : lv - dec;
`endif
                  if (lv == 0) st = S_IDLE;
               end
            endcase
         end
         m_out   <= (m_lv == 0) ? 0 : (int'(data_in) * (m_lv + 1)) / 256;
         m_st    <= st;
         m_lv    <= lv;
         m_gq    <= gate;
         m_armed <= m_armed || !gate;
         m_cnt   <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
      end
   end

   // Advance to just after the next tick edge (bounded).
   task automatic next_tick();
      int n = 0;
      while (m_cnt != TD - 1 && n < 3 * TD) begin
         @(posedge clk); #1; n++;
      end
      if (m_cnt != TD - 1) begin
         n_cmp++; n_fail++;
         $display("FAIL tick_wait: tick not found within %0d clocks", 3 * TD);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      n_cmp++; if (level !== 8'd0)    begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
      n_cmp++; if (data_out !== 8'd0) begin n_fail++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_attack();
      int exp_l[4] = '{64, 128, 192, 255};
      attack_step = 8'd64; data_in = 8'hFF;
      gate = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL attack_busy: got %0b want 1", busy); end
      for (int i = 0; i < 4; i++) begin
         next_tick();
         n_cmp++;
         if (level !== 8'(exp_l[i])) begin n_fail++; $display("FAIL attack_level%0d: got %0d want %0d", i, level, exp_l[i]); end
      end
      @(posedge clk); #1;
      n_cmp++; if (data_out !== 8'hFF) begin n_fail++; $display("FAIL attack_data_out: got %0h want ff", data_out); end
   endtask

   task automatic test_decay_sustain();
      int exp_l[4] = '{223, 191, 159, 128};
      decay_step = 8'd32; sustain_level = 8'h80;
      for (int i = 0; i < 4; i++) begin
         next_tick();
         n_cmp++;
         if (level !== 8'(exp_l[i])) begin n_fail++; $display("FAIL decay_level%0d: got %0d want %0d", i, level, exp_l[i]); end
      end
      @(posedge clk); #1;
      n_cmp++; if (data_out !== 8'h80) begin n_fail++; $display("FAIL sustain_data_out: got %0h want 80", data_out); end
      sustain_level = 8'h40;
      next_tick();
      n_cmp++; if (level !== 8'h40) begin n_fail++; $display("FAIL sustain_track_down: got %0h want 40", level); end
      sustain_level = 8'h80;
      next_tick();
      n_cmp++; if (level !== 8'h80) begin n_fail++; $display("FAIL sustain_track_up: got %0h want 80", level); end
      n_cmp++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL sustain_busy: got %0b want 1", busy); end
   endtask

   task automatic test_release();
      int n = 0;
`ifdef ENV_EXP_RELEASE_EN
      int exp_l[4] = '{96, 72, 54, 41};
      release_step = 8'd0;
`else
      int exp_l[2] = '{64, 0};
      release_step = 8'h40;
`endif
      gate = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (level !== 8'h80 || busy !== 1'b1) begin
         n_fail++; $display("FAIL release_entry: got level %0h busy %0b want 80 1", level, busy);
      end
      foreach (exp_l[i]) begin
         next_tick();
         n_cmp++;
         if (level !== 8'(exp_l[i])) begin n_fail++; $display("FAIL release_level%0d: got %0d want %0d", i, level, exp_l[i]); end
      end
      while (level !== 8'd0 && n < 40) begin
         next_tick(); n++;
      end
      n_cmp++; if (level !== 8'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL release_end: got level %0d busy %0b want 0 0", level, busy);
      end
      @(posedge clk); #1;
      n_cmp++; if (data_out !== 8'd0) begin n_fail++; $display("FAIL release_data_out: got %0d want 0", data_out); end
   endtask

   task automatic test_retrigger();
      int n = 0;
`ifdef ENV_EXP_RELEASE_EN
      int rel_l = 96;
`else
      int rel_l = 64;
`endif
      attack_step = 8'd0; decay_step = 8'd0; sustain_level = 8'h80;
      gate = 1'b1;
      next_tick();
      n_cmp++; if (level !== 8'd255) begin n_fail++; $display("FAIL attack_step0: got %0d want 255", level); end
      next_tick();
      n_cmp++; if (level !== 8'h80)  begin n_fail++; $display("FAIL decay_step0: got %0d want 128", level); end
      gate = 1'b0;
      @(posedge clk); #1;
      next_tick();
      n_cmp++; if (level !== 8'(rel_l)) begin n_fail++; $display("FAIL retrig_rel_level: got %0d want %0d", level, rel_l); end
      while (m_cnt != TD - 1 && n < 3 * TD) begin
         @(posedge clk); #1; n++;
      end
      attack_step = 8'd64;
      gate = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (level !== 8'(rel_l) || busy !== 1'b1) begin
         n_fail++; $display("FAIL retrig_hold: got level %0d busy %0b want %0d 1", level, busy, rel_l);
      end
      next_tick();
      n_cmp++; if (level !== 8'(rel_l + 64)) begin n_fail++; $display("FAIL retrig_attack: got %0d want %0d", level, rel_l + 64); end
   endtask

   task automatic test_async_reset();
      next_tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (level !== 8'd0 || busy !== 1'b0 || data_out !== 8'd0) begin
         n_fail++; $display("FAIL async_reset: got level %0d busy %0b data_out %0d want 0 0 0", level, busy, data_out);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      n_cmp++; if (level !== 8'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL held_gate_no_restart: got level %0d busy %0b want 0 0", level, busy);
      end
      gate = 1'b0;
      repeat (2) @(posedge clk);
      #1 gate = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL new_rise_after_reset: got busy %0b want 1", busy); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1200; c++) begin
         data_in = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 11) == 0) gate = ~gate;
         if ($urandom_range(0, 39) == 0) begin
            attack_step   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            decay_step    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            sustain_level = 8'($urandom_range(0, 255));
            release_step  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         end
         @(posedge clk); #1;
         n_cmp++;
         if (level !== 8'(m_lv) || busy !== (m_st != S_IDLE) || data_out !== 8'(m_out)) begin
            n_fail++;
            $display("FAIL random_c%0d: got level %0d busy %0b data_out %0d want %0d %0b %0d",
                     c, level, busy, data_out, m_lv, (m_st != S_IDLE), m_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_attack();
      test_decay_sustain();
      test_release();
      test_retrigger();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
